// File: rtl/border_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : border_phase_ctrl
//  Description : Game-phase sequencer. It produces the init/dead qualifiers and
//                the border colour used by the draw layers. It also produces a
//                one-clock frame tick derived from the raster counters.
//                Phases: attract -> serve -> play -> death blink -> over/win.
//  Ports       : clk, rst_n (sync, active low)
//                vcounter[10:0], hcounter[11:0]  raster position
//                start_btn (level), ball_lost (pulse), bricks_clear (level)
//                init, dead, border_color[3:0], lives[2:0], phase[2:0],
//                frame_tick
//  Revision    : 1.0  initial release
// ============================================================================
module border_phase_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int DEAD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcounter,
    input  logic [11:0] hcounter,
    input  logic        start_btn,
    input  logic        ball_lost,
    input  logic        bricks_clear,
    output logic        init,
    output logic        dead,
    output logic [3:0]  border_color,
    output logic [2:0]  lives,
    output logic [2:0]  phase,
    output logic        frame_tick
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DEAD  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;

    localparam logic [2:0] c_lives = 3'(LIVES);
    localparam logic [7:0] c_serve = 8'(SERVE_FRAMES);
    localparam logic [7:0] c_dead  = 8'(DEAD_FRAMES);
    localparam logic [7:0] c_blink = 8'(BLINK_FRAMES);

    logic [2:0] r_state;
    logic [2:0] r_lives;
    logic [7:0] r_cnt;
    logic [7:0] r_blink_cnt;
    logic       r_blink;
    logic       r_top_q;
    logic       r_start_q;
    logic       r_frame_tick;
    logic       r_init;
    logic       r_dead;
    logic [3:0] r_border;

    logic       w_top;
    logic       w_start_pulse;
    logic [7:0] w_cnt_inc;
    logic [7:0] w_blink_inc;
    logic [2:0] w_nxt_state;
    logic [2:0] w_nxt_lives;
    logic [7:0] w_nxt_cnt;
    logic [7:0] w_nxt_blink_cnt;
    logic       w_nxt_blink;
    logic       w_nxt_init;
    logic       w_nxt_dead;
    logic [3:0] w_nxt_border;

    assign w_top         = (vcounter == 11'd0) && (hcounter == 12'd0);
    assign w_start_pulse = start_btn & ~r_start_q;
    // Frame counter saturates so a very long dwell can never wrap it.
    assign w_cnt_inc     = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_blink_inc   = r_blink_cnt + 8'd1;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_lives     = r_lives;
        w_nxt_blink     = r_blink;
        w_nxt_blink_cnt = r_blink_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start_pulse) begin
                    w_nxt_state = S_SERVE;
                    w_nxt_lives = c_lives;
                end
            end
            S_SERVE: begin
                if (r_frame_tick && (w_cnt_inc == c_serve)) w_nxt_state = S_PLAY;
            end
            S_PLAY: begin
                if (bricks_clear) begin
                    w_nxt_state = S_WIN;
                end else if (ball_lost) begin
                    w_nxt_state     = S_DEAD;
                    w_nxt_blink     = 1'b0;
                    w_nxt_blink_cnt = 8'd0;
                end
            end
            S_DEAD: begin
                if (r_frame_tick) begin
                    if (w_blink_inc == c_blink) begin
                        w_nxt_blink     = ~r_blink;
                        w_nxt_blink_cnt = 8'd0;
                    end else begin
                        w_nxt_blink_cnt = w_blink_inc;
                    end
                    if (w_cnt_inc == c_dead) begin
                        // Guarded so lives can never wrap below zero.
                        if (r_lives <= 3'd1) begin
                            w_nxt_state = S_OVER;
                            w_nxt_lives = 3'd0;
                        end else begin
                            w_nxt_state = S_SERVE;
                            w_nxt_lives = r_lives - 3'd1;
                        end
                    end
                end
            end
            S_OVER: begin
                w_nxt_lives = 3'd0;
                if (w_start_pulse) w_nxt_state = S_IDLE;
            end
            S_WIN: begin
                if (w_start_pulse) w_nxt_state = S_SERVE;
            end
            default: w_nxt_state = S_IDLE;
        endcase

        w_nxt_cnt = (w_nxt_state != r_state) ? 8'd0
                  : (r_frame_tick ? w_cnt_inc : r_cnt);

        // Outputs are decoded from the next state so they register together
        // with the phase change.
        w_nxt_init   = 1'b0;
        w_nxt_dead   = 1'b0;
        w_nxt_border = 4'b1111;
        case (w_nxt_state)
            S_IDLE, S_SERVE: w_nxt_init = 1'b1;
            S_DEAD: begin
                w_nxt_dead   = 1'b1;
                w_nxt_border = w_nxt_blink ? 4'b1111 : 4'b0000;
            end
            S_OVER: begin
                w_nxt_dead   = 1'b1;
                w_nxt_border = 4'b0000;
            end
            S_WIN: begin
                w_nxt_init   = 1'b1;
                w_nxt_border = 4'b1010;
            end
            default: w_nxt_init = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lives      <= c_lives;
            r_cnt        <= 8'd0;
            r_blink_cnt  <= 8'd0;
            r_blink      <= 1'b0;
            r_top_q      <= 1'b0;
            r_start_q    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_init       <= 1'b1;
            r_dead       <= 1'b0;
            r_border     <= 4'b1111;
        end else begin
            r_state      <= w_nxt_state;
            r_lives      <= w_nxt_lives;
            r_cnt        <= w_nxt_cnt;
            r_blink_cnt  <= w_nxt_blink_cnt;
            r_blink      <= w_nxt_blink;
            r_top_q      <= w_top;
            r_start_q    <= start_btn;
            // Edge of the 0/0 position: one pulse even if the raster dwells.
            r_frame_tick <= w_top & ~r_top_q;
            r_init       <= w_nxt_init;
            r_dead       <= w_nxt_dead;
            r_border     <= w_nxt_border;
        end
    end

    assign init         = r_init;
    assign dead         = r_dead;
    assign border_color = r_border;
    assign lives        = r_lives;
    assign phase        = r_state;
    assign frame_tick   = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_border_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_border_phase_ctrl
//  Description : Self-checking bench for border_phase_ctrl. Stimulus computes
//                the expected post-edge outputs from a game-level model and
//                queues them. A monitor compares each cycle's outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_border_phase_ctrl;

    localparam int c_lives = 3;
    localparam int c_serve = 4;
    localparam int c_dead  = 6;
    localparam int c_blink = 2;
    localparam int c_hsize = 8;
    localparam int c_vsize = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] vcounter = '0;
    logic [11:0] hcounter = '0;
    logic        start_btn = 1'b0;
    logic        ball_lost = 1'b0;
    logic        bricks_clear = 1'b0;
    logic        init;
    logic        dead;
    logic [3:0]  border_color;
    logic [2:0]  lives;
    logic [2:0]  phase;
    logic        frame_tick;

    border_phase_ctrl #(
        .LIVES       (c_lives),
        .SERVE_FRAMES(c_serve),
        .DEAD_FRAMES (c_dead),
        .BLINK_FRAMES(c_blink)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vcounter    (vcounter),
        .hcounter    (hcounter),
        .start_btn   (start_btn),
        .ball_lost   (ball_lost),
        .bricks_clear(bricks_clear),
        .init        (init),
        .dead        (dead),
        .border_color(border_color),
        .lives       (lives),
        .phase       (phase),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // {init, dead, border[3:0], lives[2:0], phase[2:0], frame_tick}
    logic [12:0] r_expq[$];
    int          r_checks = 0;
    int          r_errors = 0;
    bit          r_done   = 1'b0;

    // Game-level reference state
    int m_phase, m_lives, m_frames;
    bit m_tick, m_top_q, m_start_q;

    // Raster generator state
    int rv = 0, rh = 0, rdwell = 0, dwell_req = 0;

    task automatic model_step(input bit r, input bit s, input bit l, input bit c,
                              input int v, input int h);
        bit top, sp;
        int nf, np;
        bit e_init, e_dead;
        logic [3:0] e_border;
        top = (v == 0) && (h == 0);
        if (!r) begin
            m_phase = 0; m_lives = c_lives; m_frames = 0;
            m_tick = 0; m_top_q = 0; m_start_q = 0;
        end else begin
            sp = s && !m_start_q;
            nf = m_frames + (m_tick ? 1 : 0);
            if (nf > 255) nf = 255;
            np = m_phase;
            case (m_phase)
                0: if (sp) begin np = 1; m_lives = c_lives; end
                1: if (m_tick && nf == c_serve) np = 2;
                2: if (c) np = 5; else if (l) np = 3;
                3: if (m_tick && nf == c_dead) begin
                       if (m_lives > 0) m_lives = m_lives - 1;
                       np = (m_lives == 0) ? 4 : 1;
                   end
                4: if (sp) np = 0;
                5: if (sp) np = 1;
                default: np = 0;
            endcase
            m_frames = (np != m_phase) ? 0 : nf;
            m_phase  = np;
            m_tick    = top && !m_top_q;
            m_top_q   = top;
            m_start_q = s;
        end
        e_init = (m_phase == 0) || (m_phase == 1) || (m_phase == 5);
        e_dead = (m_phase == 3) || (m_phase == 4);
        case (m_phase)
            3: e_border = (((m_frames / c_blink) % 2) == 1) ? 4'b1111 : 4'b0000;
            4: e_border = 4'b0000;
            5: e_border = 4'b1010;
            default: e_border = 4'b1111;
        endcase
        r_expq.push_back({e_init, e_dead, e_border, 3'(m_lives), 3'(m_phase), m_tick});
    endtask

    // Drive one clock of inputs (called while clk is low), queue expectation.
    task automatic step(input bit r, input bit s, input bit l, input bit c);
        rst_n = r; start_btn = s; ball_lost = l; bricks_clear = c;
        vcounter = 11'(rv); hcounter = 12'(rh);
        model_step(r, s, l, c, rv, rh);
        @(negedge clk);
        if (rv == 0 && rh == 0 && rdwell > 0) begin
            rdwell--;
        end else begin
            rh++;
            if (rh == c_hsize) begin
                rh = 0; rv++;
                if (rv == c_vsize) begin
                    rv = 0; rdwell = dwell_req; dwell_req = 0;
                end
            end
        end
    endtask

    task automatic run(input int n, input bit s, input bit l, input bit c);
        for (int i = 0; i < n; i++) step(1'b1, s, l, c);
    endtask

    task automatic pulse_start();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0, 1'b0);
    endtask

    localparam int c_frame = c_hsize * c_vsize;

    initial begin : stim
        bit s_lvl, c_lvl;
        // Reset and attract
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0, 1'b0);
        // Start held for three frames: one transition only
        run(3 * c_frame, 1'b1, 1'b0, 1'b0);
        run(2 * c_frame, 1'b0, 1'b0, 1'b0);
        // Raster dwells on 0/0 for five clocks
        dwell_req = 4;
        run(2 * c_frame, 1'b0, 1'b0, 1'b0);
        // Three deaths down to game over
        for (int d = 0; d < 3; d++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            run(7 * c_frame, 1'b0, 1'b0, 1'b0);
            if (d < 2) run(5 * c_frame, 1'b0, 1'b1, 1'b0);
        end
        pulse_start();
        pulse_start();
        run(6 * c_frame, 1'b0, 1'b0, 1'b0);
        // Simultaneous loss and clear: win has priority
        step(1'b1, 1'b0, 1'b1, 1'b1);
        run(10, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run(6 * c_frame, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of the death blink
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run(3 * c_frame + 5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run(2 * c_frame, 1'b0, 1'b0, 1'b0);
        // Randomised play
        s_lvl = 0; c_lvl = 0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 99) < 3) s_lvl = ~s_lvl;
            if ($urandom_range(0, 399) == 0) c_lvl = 1;
            else if ($urandom_range(0, 19) == 0) c_lvl = 0;
            if ($urandom_range(0, 199) == 0) dwell_req = $urandom_range(1, 4);
            step(($urandom_range(0, 2999) != 0), s_lvl,
                 ($urandom_range(0, 39) == 0), c_lvl);
        end
        @(posedge clk);
        #2;
        r_done = 1'b1;
    end

    initial begin : monitor
        logic [12:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            if (r_expq.size() > 0) begin
                exp_v = r_expq.pop_front();
                act_v = {init, dead, border_color, lives, phase, frame_tick};
                r_checks++;
                if (act_v !== exp_v) begin
                    r_errors++;
                    $display("FAIL outputs t=%0t got init=%b dead=%b border=%b lives=%0d phase=%0d tick=%b expected init=%b dead=%b border=%b lives=%0d phase=%0d tick=%b",
                             $time, act_v[12], act_v[11], act_v[10:7], act_v[6:4], act_v[3:1], act_v[0],
                             exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:4], exp_v[3:1], exp_v[0]);
                end
            end
        end
    end

    initial begin : finisher
        wait (r_done);
        if (r_expq.size() != 0) begin
            r_errors++;
            $display("FAIL queue_drain got %0d pending expected 0", r_expq.size());
        end
        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/border_phase_ctrl.md
Name: border_phase_ctrl

Overview:
- Game-phase sequencer that drives the `init`/`dead` qualifiers and the border colour consumed by the background/border drawer.
- Runs a per-frame state machine: attract → serve → play → death blink → game over / win.
- Derives a single-cycle frame tick from the raster counters, so all phase timing is in whole video frames.
- Sits between the input/collision logic and the draw layers.

Parameters:
- LIVES, 3, lives loaded at game start (1..7).
- SERVE_FRAMES, 60, frames `init` is held before play resumes (1..255).
- DEAD_FRAMES, 120, frames spent in the death blink (1..255).
- BLINK_FRAMES, 8, half-period of the border blink in frames (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- vcounter  in  11  raster line counter
- hcounter  in  12  raster pixel counter
- start_btn  in  1  start button level, already synchronised
- ball_lost  in  1  single-cycle pulse: ball left the field
- bricks_clear  in  1  level: no bricks remain
- init  out  1  serve/attract phase qualifier to the draw layers
- dead  out  1  death/game-over qualifier to the draw layers
- border_color  out  4  border colour for the border drawer
- lives  out  3  remaining lives
- phase  out  3  state code: IDLE=0, SERVE=1, PLAY=2, DEAD=3, OVER=4, WIN=5
- frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (rst_n low at a clk edge), applied in any state, takes effect the same edge:
  - phase=IDLE, init=1, dead=0, border_color=4'b1111, lives=LIVES, frame_tick=0.
  - Frame counter, blink phase and edge-detect registers are cleared.
- Frame tick:
  - top = (vcounter==0 && hcounter==0).
  - frame_tick = top & ~top_q, registered, so it rises one cycle after top first becomes true.
  - Exactly one pulse per frame, even if the counters dwell on 0/0 for several clocks.
- Start edge: start_pulse = start_btn & ~start_q. Holding the button never retriggers.
- Frame counter: 8-bit, cleared on every state entry, incremented on frame_tick, saturates at 255.
- IDLE:
  - Outputs: init=1, dead=0, border solid 1111.
  - start_pulse → SERVE; lives reloaded to LIVES.
- SERVE:
  - Outputs: init=1, dead=0, border 1111.
  - On the frame_tick where the counter reaches SERVE_FRAMES → PLAY.
- PLAY:
  - Outputs: init=0, dead=0, border 1111.
  - bricks_clear → WIN. This has priority over a same-cycle ball_lost.
  - Otherwise ball_lost → DEAD.
- DEAD:
  - Outputs: init=0, dead=1.
  - Border toggles between 1111 and 0000 every BLINK_FRAMES frame_ticks, starting at 0000 on entry.
  - On the frame_tick where the counter reaches DEAD_FRAMES, lives decrements by 1:
    - lives becomes 0 → OVER.
    - otherwise → SERVE.
  - ball_lost and bricks_clear are ignored.
- OVER:
  - Outputs: dead=1, init=0, border solid 0000, lives=0.
  - start_pulse → IDLE. The next start_pulse begins a new game.
- WIN:
  - Outputs: init=1, dead=0, border solid 1010, lives unchanged.
  - start_pulse → SERVE with lives unchanged.
- All outputs are registered and update on the same edge as the state change.
- lives never underflows: a decrement only happens from lives ≥ 1.
- ball_lost arriving in any state other than PLAY is dropped, not queued.
- Unused phase codes 6 and 7 recover to IDLE on the next clock.

Test Plan:
1. Reset, then feed raster frames with SERVE_FRAMES=4 → phase=0, init=1. Pulse start_btn → phase=1. After the 4th frame_tick → phase=2, init=0.
2. Counters hold 0/0 for 5 clocks → exactly one frame_tick, one clock after first 0/0. Holding start_btn high for 3 frames → only one transition.
3. PLAY with LIVES=3, DEAD_FRAMES=6, BLINK_FRAMES=2, pulse ball_lost:
   - dead=1; border sequence per frame 0000,0000,1111,1111,0000,0000.
   - Then lives=2, phase=1.
4. Three deaths from LIVES=3 → after the third, lives=0, phase=4, dead=1, border 0000. Pulse start → phase=0. Pulse start → phase=1, lives=3.
5. In PLAY, assert ball_lost and bricks_clear in the same cycle → phase=5, border 1010, lives unchanged. Pulse start → phase=1.
6. Drop rst_n mid-DEAD (frame 3 of 6) → next edge phase=0, dead=0, lives=LIVES, border 1111, no stale blink on resumption.
